// File: rtl/reg_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : reg_share_arbiter
//  Purpose  : Round-robin owner arbitration and load sequencing for one shared
//             WIDTH-bit register bank; optional Q bit-toggle counter built only
//             when TOGGLE_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                       CLK,
    input  logic                       CLR_BAR,
    input  logic [N_REQ-1:0]           REQ,
    input  logic [N_REQ*WIDTH-1:0]     DATA_IN,
    output logic [N_REQ-1:0]           GNT,
    output logic [N_REQ-1:0]           ACK,
    output logic [$clog2(N_REQ)-1:0]   OWNER,
    output logic                       BUSY,
    output logic [WIDTH-1:0]           Q,
    output logic [15:0]                TOGGLE_CNT
);

    localparam int OWNER_W = $clog2(N_REQ);
    localparam int CAND_W  = OWNER_W + 1;
    localparam int CNT_W   = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   ptr_q, ptr_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;

    logic                 win_found;
    logic [OWNER_W-1:0]   win_idx;
    logic [CAND_W-1:0]    cand;
    logic                 owner_req;
    logic [WIDTH-1:0]     owner_data;
    logic [OWNER_W-1:0]   ptr_after_owner;
    logic                 load_en;

    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] a);
        logic [CAND_W-1:0] s;
        s = {1'b0, a} + 1'b1;
        if (s >= CAND_W'(N_REQ))
            s = '0;
        return s[OWNER_W-1:0];
    endfunction

    // Search upward from the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int j = 0; j < N_REQ; j++) begin
            cand = {1'b0, ptr_q} + CAND_W'(j);
            if (cand >= CAND_W'(N_REQ))
                cand = cand - CAND_W'(N_REQ);
            if (!win_found && REQ[cand[OWNER_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                owner_req  = REQ[i];
                owner_data = DATA_IN[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_after_owner = wrap_inc(owner_q);
    assign load_en         = (state_q == S_GRANT) && owner_req;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ack_d      = '0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        q_d        = q_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_GRANT;
                    gnt_d   = N_REQ'(1) << win_idx;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                end
            end
            S_GRANT: begin
                if (owner_req) begin
                    state_d    = S_HOLD;
                    q_d        = owner_data;
                    ack_d      = gnt_q;
                    hold_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_owner;
                end
            end
            S_HOLD: begin
                if (!owner_req || (hold_cnt_q == C_HOLD_LAST)) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_owner;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef TOGGLE_CNT_EN
    logic [15:0]      tcnt_q, tcnt_d;
    logic [16:0]      tsum;
    logic [WIDTH-1:0] tdiff;

    // One extra bit catches overflow so the count can saturate.
    always_comb begin
        tdiff = q_q ^ owner_data;
        tsum  = {1'b0, tcnt_q};
        for (int b = 0; b < WIDTH; b++)
            tsum = tsum + 17'(tdiff[b]);
        tcnt_d = tcnt_q;
        if (load_en)
            tcnt_d = tsum[16] ? 16'hFFFF : tsum[15:0];
    end

    assign TOGGLE_CNT = tcnt_q;
`else
    assign TOGGLE_CNT = 16'h0000;
`endif

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            ack_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            q_q        <= '0;
            hold_cnt_q <= '0;
`ifdef TOGGLE_CNT_EN
            tcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            q_q        <= q_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef TOGGLE_CNT_EN
            tcnt_q     <= tcnt_d;
`endif
        end
    end

    assign GNT   = gnt_q;
    assign ACK   = ack_q;
    assign OWNER = owner_q;
    assign BUSY  = busy_q;
    assign Q     = q_q;

endmodule
`default_nettype wire
